// File: rtl/mem_commit_if.sv
// Commit-side memory interface: ROB/regfile request inputs, data memory port,
// and completion results back to the ROB.
interface mem_commit_if;
  logic        data_read;
  logic        data_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic [3:0]  data_mem_mbe;
  logic        data_mem_read;
  logic        data_mem_write;
  logic [31:0] ld_data;
  logic        mem_done;
  logic        access_fault;
  logic        busy;

  modport slave (
    input  data_read, data_write, funct3, addr, st_data, data_mem_rdata, data_mem_resp,
    output data_mem_address, data_mem_wdata, data_mem_mbe, data_mem_read, data_mem_write,
           ld_data, mem_done, access_fault, busy
  );

  modport master (
    output data_read, data_write, funct3, addr, st_data, data_mem_rdata, data_mem_resp,
    input  data_mem_address, data_mem_wdata, data_mem_mbe, data_mem_read, data_mem_write,
           ld_data, mem_done, access_fault, busy
  );
endinterface

// File: rtl/mem_commit_unit.sv
// Executes the committing load/store at the ROB head against data memory:
// IDLE -> REQ (strobe held until resp) -> DONE (one-cycle mem_done pulse).
module mem_commit_unit (
  input  logic         clk,
  input  logic         rst,
  mem_commit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] sd_q;
  logic        op_q;        // 1 = store
  logic        rd_reg;
  logic        wr_reg;
  logic        done_reg;
  logic        fault_reg;
  logic        busy_reg;
  logic [3:0]  mbe_reg;
  logic [31:0] ld_data_reg;

  logic        is_fault;
  logic [3:0]  mbe_next;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    is_fault = 1'b0;
    case (bus.funct3)
      3'b011, 3'b110, 3'b111: is_fault = 1'b1;
      3'b001, 3'b101:         is_fault = bus.addr[0];
      3'b010:                 is_fault = (bus.addr[1:0] != 2'b00);
      default:                is_fault = 1'b0;
    endcase
  end

  always_comb begin
    mbe_next = 4'b1111;
    case (bus.funct3[1:0])
      2'b00:   mbe_next = 4'b0001 << bus.addr[1:0];
      2'b01:   mbe_next = 4'b0011 << bus.addr[1:0];
      default: mbe_next = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes; the mbe picks the live bytes.
  always_comb begin
    wdata = sd_q;
    case (f3_q[1:0])
      2'b00:   wdata = {4{sd_q[7:0]}};
      2'b01:   wdata = {2{sd_q[15:0]}};
      default: wdata = sd_q;
    endcase
  end

  assign ld_byte = bus.data_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = bus.data_mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = bus.data_mem_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.data_mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      sd_q        <= '0;
      op_q        <= 1'b0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      mbe_reg     <= '0;
      ld_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg  <= 1'b0;
          fault_reg <= 1'b0;
          if (bus.data_read || bus.data_write) begin
            addr_q   <= bus.addr;
            f3_q     <= bus.funct3;
            sd_q     <= bus.st_data;
            op_q     <= bus.data_write;
            busy_reg <= 1'b1;
            if (is_fault) begin
              // Illegal access completes without touching memory.
              state_reg <= DONE;
              done_reg  <= 1'b1;
              fault_reg <= 1'b1;
            end else begin
              state_reg <= REQ;
              rd_reg    <= ~bus.data_write;
              wr_reg    <= bus.data_write;
              mbe_reg   <= mbe_next;
            end
          end
        end
        REQ: begin
          if (bus.data_mem_resp) begin
            state_reg <= DONE;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            done_reg  <= 1'b1;
            if (!op_q) ld_data_reg <= ld_ext;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          fault_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.data_mem_address = {addr_q[31:2], 2'b00};
  assign bus.data_mem_wdata   = wdata;
  assign bus.data_mem_mbe     = mbe_reg;
  assign bus.data_mem_read    = rd_reg;
  assign bus.data_mem_write   = wr_reg;
  assign bus.ld_data          = ld_data_reg;
  assign bus.mem_done         = done_reg;
  assign bus.access_fault     = fault_reg;
  assign bus.busy             = busy_reg;
endmodule

// File: tb/tb_mem_commit_unit.sv
// Directed table-driven bench for mem_commit_unit plus hand-written reset/stray-resp sequences.
module tb_mem_commit_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_commit_if bus ();

  mem_commit_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          delay;
    logic        exp_fault;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_req();
    bus.data_read     = 1'b0;
    bus.data_write    = 1'b0;
    bus.data_mem_resp = 1'b0;
    bus.data_mem_rdata = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    bus.data_read  = v.rd;
    bus.data_write = v.wr;
    bus.funct3     = v.f3;
    bus.addr       = v.addr;
    bus.st_data    = v.sd;
    bus.data_mem_resp  = 1'b0;
    bus.data_mem_rdata = 32'h0;
    @(negedge clk);
    if (v.exp_fault) begin
      chk("fault_done", {31'd0, bus.mem_done}, 32'd1);
      chk("fault_flag", {31'd0, bus.access_fault}, 32'd1);
      chk("fault_nostrobe", {30'd0, bus.data_mem_read, bus.data_mem_write}, 32'd0);
      chk("fault_ld", bus.ld_data, v.exp_ld);
      drop_req();
      @(negedge clk);
      chk("fault_pulse_end", {30'd0, bus.mem_done, bus.access_fault}, 32'd0);
    end else begin
      chk("strobe", {30'd0, bus.data_mem_read, bus.data_mem_write}, {30'd0, ~v.exp_wr, v.exp_wr});
      chk("address", bus.data_mem_address, v.exp_addr);
      chk("mbe", {28'd0, bus.data_mem_mbe}, {28'd0, v.exp_mbe});
      if (v.exp_wr) chk("wdata", bus.data_mem_wdata, v.exp_wdata);
      chk("busy_req", {31'd0, bus.busy}, 32'd1);
      for (int c = 0; c < v.delay; c++) begin
        @(negedge clk);
        chk("hold_strobe", {30'd0, bus.data_mem_read, bus.data_mem_write}, {30'd0, ~v.exp_wr, v.exp_wr});
        chk("hold_addr", bus.data_mem_address, v.exp_addr);
        chk("no_early_done", {31'd0, bus.mem_done}, 32'd0);
      end
      bus.data_mem_resp  = 1'b1;
      bus.data_mem_rdata = v.rdata;
      @(negedge clk);
      bus.data_mem_resp  = 1'b0;
      bus.data_mem_rdata = 32'h0;
      chk("mem_done", {31'd0, bus.mem_done}, 32'd1);
      chk("no_fault", {31'd0, bus.access_fault}, 32'd0);
      chk("strobe_drop", {30'd0, bus.data_mem_read, bus.data_mem_write}, 32'd0);
      chk("ld_data", bus.ld_data, v.exp_ld);
      drop_req();
      @(negedge clk);
      chk("done_pulse_end", {31'd0, bus.mem_done}, 32'd0);
      chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    end
    $display("txn %0d: rd=%0b wr=%0b f3=%0d addr=%h ld_data=%h", idx, v.rd, v.wr, v.f3, v.addr, bus.ld_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           rd  wr  f3      addr          sd            rdata        dly flt wr  exp_addr      mbe      wdata         ld
    vecs[0]  = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        32'hDEADBEEF,2, 1'b0,1'b0,32'h0000_0100,4'b1111,32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1,1'b0,3'b000,32'h0000_0203,32'h0,        32'h80FF1234,0, 1'b0,1'b0,32'h0000_0200,4'b1000,32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1,1'b0,3'b100,32'h0000_0203,32'h0,        32'h80FF1234,1, 1'b0,1'b0,32'h0000_0200,4'b1000,32'h0,        32'h00000080};
    vecs[3]  = '{1'b0,1'b1,3'b001,32'h0000_0302,32'h1234ABCD,32'h55555555,1, 1'b0,1'b1,32'h0000_0300,4'b1100,32'hABCDABCD,32'h00000080};
    vecs[4]  = '{1'b1,1'b0,3'b001,32'h0000_0102,32'h0,        32'h80FF1234,0, 1'b0,1'b0,32'h0000_0100,4'b1100,32'h0,        32'hFFFF80FF};
    vecs[5]  = '{1'b1,1'b0,3'b101,32'h0000_0100,32'h0,        32'h80FF9234,3, 1'b0,1'b0,32'h0000_0100,4'b0011,32'h0,        32'h00009234};
    vecs[6]  = '{1'b0,1'b1,3'b000,32'h0000_0401,32'h000000A5,32'h0,        0, 1'b0,1'b1,32'h0000_0400,4'b0010,32'hA5A5A5A5,32'h00009234};
    vecs[7]  = '{1'b0,1'b1,3'b010,32'h0000_0500,32'hCAFEF00D,32'h0,        2, 1'b0,1'b1,32'h0000_0500,4'b1111,32'hCAFEF00D,32'h00009234};
    vecs[8]  = '{1'b1,1'b0,3'b010,32'h0000_0101,32'h0,        32'h0,        0, 1'b1,1'b0,32'h0,        4'b0000,32'h0,        32'h00009234};
    vecs[9]  = '{1'b1,1'b0,3'b011,32'h0000_0100,32'h0,        32'h0,        0, 1'b1,1'b0,32'h0,        4'b0000,32'h0,        32'h00009234};
    vecs[10] = '{1'b1,1'b0,3'b001,32'h0000_0203,32'h0,        32'h0,        0, 1'b1,1'b0,32'h0,        4'b0000,32'h0,        32'h00009234};
    vecs[11] = '{1'b1,1'b1,3'b010,32'h0000_0600,32'h11223344,32'hFFFFFFFF,1, 1'b0,1'b1,32'h0000_0600,4'b1111,32'h11223344,32'h00009234};
    vecs[12] = '{1'b1,1'b0,3'b000,32'h0000_0001,32'h0,        32'h00007F00,0, 1'b0,1'b0,32'h0000_0000,4'b0010,32'h0,        32'h0000007F};

    bus.data_read = 1'b0;
    bus.data_write = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr = 32'h0;
    bus.st_data = 32'h0;
    bus.data_mem_rdata = 32'h0;
    bus.data_mem_resp = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_strobe", {30'd0, bus.data_mem_read, bus.data_mem_write}, 32'd0);
    chk("rst_flags", {29'd0, bus.mem_done, bus.access_fault, bus.busy}, 32'd0);
    chk("rst_ld", bus.ld_data, 32'd0);
    chk("rst_addr", bus.data_mem_address, 32'd0);
    chk("rst_wdata", bus.data_mem_wdata, 32'd0);
    chk("rst_mbe", {28'd0, bus.data_mem_mbe}, 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Stray resp while idle must not complete anything
    @(negedge clk);
    bus.data_mem_resp = 1'b1;
    bus.data_mem_rdata = 32'h12345678;
    @(negedge clk);
    bus.data_mem_resp = 1'b0;
    chk("stray_resp_done", {31'd0, bus.mem_done}, 32'd0);
    chk("stray_resp_ld", bus.ld_data, 32'h0000007F);
    @(negedge clk);
    chk("stray_resp_done2", {30'd0, bus.mem_done, bus.busy}, 32'd0);
    $display("txn stray_resp: mem_done=%0b ld_data=%h", bus.mem_done, bus.ld_data);

    // Reset while waiting in REQ, then a late resp
    bus.data_read = 1'b1;
    bus.funct3 = 3'b010;
    bus.addr = 32'h0000_0700;
    @(negedge clk);
    chk("rstreq_strobe_up", {31'd0, bus.data_mem_read}, 32'd1);
    rst = 1'b1;
    bus.data_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstreq_strobe_low", {30'd0, bus.data_mem_read, bus.data_mem_write}, 32'd0);
    chk("rstreq_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstreq_ld", bus.ld_data, 32'd0);
    bus.data_mem_resp = 1'b1;
    bus.data_mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    bus.data_mem_resp = 1'b0;
    chk("rstreq_no_done", {31'd0, bus.mem_done}, 32'd0);
    @(negedge clk);
    chk("rstreq_no_done2", {31'd0, bus.mem_done}, 32'd0);
    chk("rstreq_ld_kept", bus.ld_data, 32'd0);
    $display("txn reset_in_req: mem_done=%0b ld_data=%h", bus.mem_done, bus.ld_data);

    begin
      vec_t post;
      post = '{1'b1,1'b0,3'b010,32'h0000_0104,32'h0,32'h0BADF00D,1,1'b0,1'b0,32'h0000_0104,4'b1111,32'h0,32'h0BADF00D};
      run_vec(NVEC, post);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_commit_unit.md
MEM_COMMIT_UNIT -- requirements
Module: mem_commit_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk drives all state, and rst is sampled only on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 data_read  in  1  ROB head is a committing load; held until mem_done.
REQ-005 data_write  in  1  ROB head is a committing store; held until mem_done.
REQ-006 funct3  in  3  RV32I width/sign code of the head instruction.
REQ-007 addr  in  32  effective address, taken from cdb_out[head_ptr].data.
REQ-008 st_data  in  32  store source value from regfile data_out.
REQ-009 data_mem_rdata  in  32  memory read data; valid when data_mem_resp=1.
REQ-010 data_mem_resp  in  1  memory completion strobe.
REQ-011 data_mem_address  out  32  word-aligned address, {addr_q[31:2],2'b00}.
REQ-012 data_mem_wdata  out  32  lane-replicated store data.
REQ-013 data_mem_mbe  out  4  byte enables.
REQ-014 data_mem_read / data_mem_write  out  1 each  memory request strobes.
REQ-015 ld_data  out  32  extended load result, fed to the regfile_in mux.
REQ-016 mem_done  out  1  one-cycle completion pulse to the ROB.
REQ-017 access_fault  out  1  one-cycle pulse coincident with mem_done on an illegal access.
REQ-018 busy  out  1  high in REQ and DONE.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, REQ and DONE, all with registered outputs.
REQ-020 In IDLE, when (data_read|data_write) is high, the unit SHALL latch addr, funct3, st_data and the operation into addr_q, f3_q, sd_q and op_q.
REQ-021 If data_read and data_write are both high, data_write SHALL win.
REQ-022 Illegal accesses SHALL be: funct3 of 011, 110 or 111; a halfword with addr[0]=1; a word with addr[1:0]!=0.
REQ-023 On acceptance of a legal access, the FSM SHALL go IDLE->REQ, and data_mem_read or data_mem_write SHALL be high from the next cycle.
REQ-024 On acceptance of an illegal access, the FSM SHALL go IDLE->DONE with access_fault=1, with no memory strobe and ld_data unchanged.
REQ-025 In REQ, the strobe, address, mbe and wdata SHALL hold stable until the cycle data_mem_resp=1 inclusive, with no timeout.
REQ-026 On data_mem_resp in REQ, the FSM SHALL go REQ->DONE, and for a load ld_data SHALL be registered from data_mem_rdata.
REQ-027 In DONE, mem_done SHALL be 1 for exactly one cycle, then the FSM SHALL go DONE->IDLE; requests seen in DONE SHALL be ignored.
REQ-028 Latency SHALL be mem_done one cycle after data_mem_resp, with a minimum of 3 cycles from acceptance (resp on the first strobe cycle).
REQ-029 Byte enables SHALL be: byte 4'b0001<<addr_q[1:0]; half 4'b0011<<addr_q[1:0]; word 4'b1111; applied to both loads and stores.
REQ-030 Store data SHALL be: sb {4{sd_q[7:0]}}; sh {2{sd_q[15:0]}}; sw sd_q.
REQ-031 Load extraction SHALL select the byte or half at addr_q[1:0] of rdata: lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-032 ld_data SHALL hold its value until the next successful load.
REQ-033 data_mem_resp seen in IDLE or DONE SHALL be ignored.

Reset
REQ-034 Synchronous rst SHALL force IDLE and drive data_mem_read, data_mem_write, mem_done, access_fault, busy, ld_data, data_mem_address, data_mem_wdata and data_mem_mbe to 0.
REQ-035 rst asserted while in REQ SHALL drop the strobe at the next edge, and a late data_mem_resp SHALL produce no mem_done.
REQ-036 The first request after reset deasserts SHALL be accepted normally.

Verification
REQ-037 lw, addr=0x100, rdata=0xDEADBEEF, resp 2 cycles after strobe: required response is address 0x100, mbe 1111, one mem_done pulse, ld_data=0xDEADBEEF.
REQ-038 lb/lbu, addr=0x203, rdata=0x80FF1234: required response is mbe 1000; lb gives ld_data=0xFFFFFF80; lbu gives 0x00000080.
REQ-039 sh, addr=0x302, st_data=0x1234ABCD: required response is data_mem_write=1, address 0x300, mbe 1100, wdata 0xABCDABCD; ld_data unchanged.
REQ-040 lw with addr=0x101, and funct3=011: required response is no strobe, mem_done and access_fault pulsing together 2 cycles after acceptance.
REQ-041 Simultaneous data_read and data_write: required response is the store performed; a stray resp in IDLE produces no mem_done.
REQ-042 rst asserted in REQ, then resp arrives: required response is the strobe low after the edge, no mem_done, and the next lw completes correctly.
